// File: rtl/addsub_defs.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings
// and operation-select constants for the sub input.
package addsub_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple of full adders. With SERIAL_ADDSUB_OVF_EN defined
// it also exposes the carry into the slice MSB for overflow detection.
module addsub_slice #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic         cmsb_o,
`endif
  output logic         co_o
);

  logic c;

  always_comb begin
    c   = cin_i;
    s_o = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
    cmsb_o = cin_i;
`endif
    for (int unsigned i = 0; i < W; i++) begin
`ifdef SERIAL_ADDSUB_OVF_EN
      if (i == W - 1) cmsb_o = c;
`endif
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, BITS_PER_CYCLE bits per clock, LSB slice first.
// Signed overflow output is generated only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub
  import addsub_defs::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned BPC = BITS_PER_CYCLE;
  localparam int unsigned N   = WIDTH / BPC;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic [CW-1:0]        cnt_q;
  logic                 carry_q, busy_q, done_q, cout_q;
  logic [BPC-1:0]       slice_s;
  logic                 slice_co;
  logic [WIDTH+BPC-1:0] shift_w;
  logic                 last_w;

  assign shift_w = {slice_s, sum_q};
  assign last_w  = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ADDSUB_OVF_EN
  logic slice_cmsb, ovf_q;

  addsub_slice #(.W(BPC)) u_slice (
    .a_i   (a_q[BPC-1:0]),
    .b_i   (b_q[BPC-1:0]),
    .cin_i (carry_q),
    .s_o   (slice_s),
    .cmsb_o(slice_cmsb),
    .co_o  (slice_co)
  );

  // Only the final slice carries the word MSB, so capture overflow there.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q != ST_RUN) && start) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ST_RUN) && last_w) begin
      ovf_q <= slice_cmsb ^ slice_co;
    end
  end

  assign ovf = ovf_q;
`else
  addsub_slice #(.W(BPC)) u_slice (
    .a_i  (a_q[BPC-1:0]),
    .b_i  (b_q[BPC-1:0]),
    .cin_i(carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtract as a + ~b + 1: the +1 enters through the carry flop.
            a_q     <= a;
            b_q     <= (sub == OP_SUB) ? ~b : b;
            carry_q <= sub;
            sum_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> BPC;
          b_q     <= b_q >> BPC;
          sum_q   <= shift_w[WIDTH+BPC-1:BPC];
          carry_q <= slice_co;
          cnt_q   <= cnt_q + 1'b1;
          if (last_w) begin
            cout_q  <= slice_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases plus random operations
// on a 1-bit-per-cycle and a 4-bit-per-cycle instance against an arithmetic model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst, start1, start4, sub;
  logic [7:0] a, b;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic ms,
                       output logic [7:0] es, output logic ec, output logic eo);
    int unsigned full;
    logic sa, sb, sr;
    if (ms) begin
      full = {24'd0, ma} - {24'd0, mb};
      ec   = (ma >= mb);
    end else begin
      full = {24'd0, ma} + {24'd0, mb};
      ec   = (full > 255);
    end
    es = full[7:0];
    sa = ma[7]; sb = mb[7]; sr = es[7];
`ifdef SERIAL_ADDSUB_OVF_EN
    eo = ms ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`else
    eo = 1'b0;
`endif
  endtask

  task automatic check_result(input string tag, input int sel,
                              input logic [7:0] ma, input logic [7:0] mb, input logic ms);
    logic [7:0] es;
    logic ec, eo;
    model(ma, mb, ms, es, ec, eo);
    check({tag, ".done"}, sel ? done4 : done1, 1);
    check({tag, ".busy_at_done"}, sel ? busy4 : busy1, 0);
    check({tag, ".sum"}, sel ? sum4 : sum1, es);
    check({tag, ".cout"}, sel ? cout4 : cout1, ec);
    check({tag, ".ovf"}, sel ? ovf4 : ovf1, eo);
  endtask

  // Start in cycle 0; expect busy in cycles 1..N and done/results in cycle N+1.
  task automatic do_op(input string tag, input int sel,
                       input logic [7:0] ta, input logic [7:0] tb, input logic ts);
    int n;
    n = sel ? 2 : 8;
    @(negedge clk);
    a = ta; b = tb; sub = ts;
    if (sel != 0) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    for (int c = 1; c <= n; c++) begin
      check({tag, ".busy"}, sel ? busy4 : busy1, 1);
      check({tag, ".done_early"}, sel ? done4 : done1, 0);
      @(negedge clk);
    end
    check_result(tag, sel, ta, tb, ts);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", busy1, 0);
    check("rst.done", done1, 0);
    check("rst.sum",  sum1,  0);
    check("rst.cout", cout1, 0);
    check("rst.ovf",  ovf1,  0);
    rst = 1'b0;

    do_op("add_3c_0f", 0, 8'h3C, 8'h0F, 1'b0);
    check("add_3c_0f.sum_const", sum1, 8'h4B);
    do_op("sub_05_07", 0, 8'h05, 8'h07, 1'b1);
    check("sub_05_07.sum_const", sum1, 8'hFE);
    do_op("sub_07_05", 0, 8'h07, 8'h05, 1'b1);
    check("sub_07_05.cout_const", cout1, 1);
    do_op("add_7f_01", 0, 8'h7F, 8'h01, 1'b0);
    do_op("add_ff_01", 0, 8'hFF, 8'h01, 1'b0);
    check("add_ff_01.sum_const", sum1, 8'h00);

    // Results hold after done until the next start.
    @(negedge clk);
    check("hold.sum", sum1, 8'h00);
    check("hold.cout", cout1, 1);
    check("hold.done", done1, 0);

    do_op("bpc4_a5_5a", 1, 8'hA5, 8'h5A, 1'b0);
    check("bpc4_a5_5a.sum_const", sum4, 8'hFF);

    // Back-to-back: start held high through DONE on the 4-bit instance.
    @(negedge clk);
    a = 8'h81; b = 8'h23; sub = 1'b0; start4 = 1'b1;
    @(negedge clk); check("b2b.busy1", busy4, 1);
    @(negedge clk); check("b2b.busy2", busy4, 1);
    @(negedge clk);
    check_result("b2b.first", 1, 8'h81, 8'h23, 1'b0);
    a = 8'h10; b = 8'h90; sub = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("b2b.no_idle_busy", busy4, 1);
    check("b2b.no_idle_done", done4, 0);
    @(negedge clk); check("b2b.busy4", busy4, 1);
    @(negedge clk);
    check_result("b2b.second", 1, 8'h10, 8'h90, 1'b1);

    // Reset in cycle 4 of a run abandons it without a done pulse.
    @(negedge clk);
    a = 8'h55; b = 8'h66; sub = 1'b0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.busy", busy1, 0);
    check("midrst.sum", sum1, 0);
    check("midrst.done", done1, 0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check("midrst.no_done", done1, 0);
      @(negedge clk);
    end

    // Start while busy is ignored.
    a = 8'h12; b = 8'h34; sub = 1'b0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (5) @(negedge clk);
    check_result("busy_start", 0, 8'h12, 8'h34, 1'b0);
    check("busy_start.sum_const", sum1, 8'h46);

    for (int i = 0; i < 24; i++) begin
      do_op("rand", int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
